// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store control unit.
// The optional split of misaligned accesses is enabled by MISALIGN_SPLIT_EN.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StAcc0   = 3'd1;
   localparam logic [2:0] StAcc1   = 3'd2;
   localparam logic [2:0] StSettle = 3'd3;
   localparam logic [2:0] StResp   = 3'd4;

   localparam int unsigned WriteSettleMax = 3;

   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   // Unshifted byte-enable pattern for the access width.
   function automatic logic [3:0] byte_ones(input logic [2:0] funct3);
      byte_ones = 4'((5'd1 << size_bytes(funct3)) - 5'd1);
   endfunction

   function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
      if (is_store) begin
         funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end else begin
         funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                        (funct3 == F3_BU) || (funct3 == F3_HU);
      end
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result extraction: shifts the (possibly two-word) read data down by the byte
// offset, then sign- or zero-extends the selected byte, halfword or word.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic        sext;

   always_comb begin
      shifted = 32'({word1, word0} >> {off, 3'b000});
      sext    = ~funct3[2];
      case (funct3[1:0])
         2'b00:   data = {{24{sext & shifted[7]}}, shifted[7:0]};
         2'b01:   data = {{16{sext & shifted[15]}}, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control unit: one request at a time, aligned memory strobes, load extension.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned WRITE_SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] SettleLast =
      2'((WRITE_SETTLE_CYCLES == 0) ? 0 : WRITE_SETTLE_CYCLES - 1);
   localparam logic [2:0] StAfterStore = (WRITE_SETTLE_CYCLES == 0) ? StResp : StSettle;

   logic [2:0]  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] word1_q, word1_d;
   logic [1:0]  cnt_q, cnt_d;

   logic        req_legal, req_misaligned;
   logic [3:0]  mask_lo;
   logic [31:0] word_addr;
   logic [31:0] load_data;
`ifdef MISALIGN_SPLIT_EN
   logic [3:0]  mask_hi;
   logic        cross;
`endif

   always_comb begin
      req_legal = funct3_legal(req_is_store, req_funct3);
`ifdef MISALIGN_SPLIT_EN
      req_misaligned = 1'b0;
`else
      req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
   end

   // Masks and address come only from latched request state, never from req_*.
   always_comb begin
      mask_lo   = 4'(byte_ones(funct3_q) << addr_q[1:0]);
      word_addr = {addr_q[31:2], 2'b00};
`ifdef MISALIGN_SPLIT_EN
      mask_hi   = 4'(({4'b0000, byte_ones(funct3_q)} << addr_q[1:0]) >> 4);
      cross     = |mask_hi;
`endif
   end

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      word0_d    = word0_q;
      word1_d    = word1_q;
      cnt_d      = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               is_store_d = req_is_store;
               funct3_d   = req_funct3;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               err_d      = !req_legal || req_misaligned;
               state_d    = (!req_legal || req_misaligned) ? StResp : StAcc0;
            end
         end
         StAcc0: begin
            if (!is_store_q) word0_d = mem_rdata;
            cnt_d   = 2'd0;
            state_d = is_store_q ? StAfterStore : StResp;
`ifdef MISALIGN_SPLIT_EN
            if (cross) state_d = StAcc1;
`endif
         end
`ifdef MISALIGN_SPLIT_EN
         StAcc1: begin
            if (!is_store_q) word1_d = mem_rdata;
            state_d = is_store_q ? StAfterStore : StResp;
         end
`endif
         StSettle: begin
            if (cnt_q == SettleLast) state_d = StResp;
            else cnt_d = cnt_q + 2'd1;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         err_q      <= 1'b0;
         word0_q    <= 32'd0;
         word1_q    <= 32'd0;
         cnt_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         word0_q    <= word0_d;
         word1_q    <= word1_d;
         cnt_q      <= cnt_d;
      end
   end

   lsu_load_align u_load_align (
      .word0  (word0_q),
      .word1  (word1_q),
      .off    (addr_q[1:0]),
      .funct3 (funct3_q),
      .data   (load_data)
   );

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_mask  = 4'd0;
      case (state_q)
         StAcc0: begin
            mem_read  = !is_store_q;
            mem_write = is_store_q;
            mem_addr  = word_addr;
            mem_mask  = mask_lo;
            if (is_store_q) mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
         end
`ifdef MISALIGN_SPLIT_EN
         StAcc1: begin
            mem_read  = !is_store_q;
            mem_write = is_store_q;
            mem_addr  = word_addr + 32'd4;
            mem_mask  = mask_hi;
            // Only reached with a non-zero offset, so the shift is 8..24 bits.
            if (is_store_q) mem_wdata = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      req_ready  = rst_n && (state_q == StIdle);
      resp_valid = (state_q == StResp);
      resp_err   = resp_valid && err_q;
      resp_rdata = (resp_valid && !err_q && !is_store_q) ? load_data : 32'd0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl; split-access expectations follow MISALIGN_SPLIT_EN.
module tb_lsu_ctrl;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_mask;

   logic [31:0] cur_a0, cur_w0, cur_w1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: first word at cur_a0, anything else returns the second word.
   assign mem_rdata = (mem_addr == cur_a0) ? cur_w0 : cur_w1;

   lsu_ctrl #(.WRITE_SETTLE_CYCLES(WS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_mask     (mem_mask),
      .mem_rdata    (mem_rdata)
   );

   typedef struct {
      string       name;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, w0, w1;
      int          nstb;
      logic [31:0] a0;
      logic [3:0]  m0;
      logic [31:0] d0, a1;
      logic [3:0]  m1;
      logic [31:0] d1, rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, wdata, w0, w1, input int nstb,
                               input logic [31:0] a0, input logic [3:0] m0,
                               input logic [31:0] d0, a1, input logic [3:0] m1,
                               input logic [31:0] d1, rdata, input logic err,
                               input int lat);
      vec_t v;
      v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.w0 = w0; v.w1 = w1; v.nstb = nstb; v.a0 = a0; v.m0 = m0; v.d0 = d0;
      v.a1 = a1; v.m1 = m1; v.d1 = d1; v.rdata = rdata; v.err = err; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic outs_any();
      return |{req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write,
               mem_addr, mem_wdata, mem_mask};
   endfunction

   task automatic run_vec(input vec_t v);
      int nstb = 0;
      int lat = 0;
      cur_a0 = {v.addr[31:2], 2'b00};
      cur_w0 = v.w0;
      cur_w1 = v.w1;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      check({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            check({v.name, " strobe kind"}, {30'd0, mem_write, mem_read},
                  v.st ? 32'd2 : 32'd1);
            if (nstb == 0) begin
               check({v.name, " addr0"}, mem_addr, v.a0);
               check({v.name, " mask0"}, 32'(mem_mask), 32'(v.m0));
               if (v.st) check({v.name, " wdata0"}, mem_wdata, v.d0);
            end else begin
               check({v.name, " addr1"}, mem_addr, v.a1);
               check({v.name, " mask1"}, 32'(mem_mask), 32'(v.m1));
               if (v.st) check({v.name, " wdata1"}, mem_wdata, v.d1);
            end
            nstb++;
         end
         if (resp_valid) begin
            lat = k;
            break;
         end
         check({v.name, " req_ready busy"}, 32'(req_ready), 32'd0);
      end
      check({v.name, " latency"}, 32'(lat), 32'(v.lat));
      check({v.name, " strobes"}, 32'(nstb), 32'(v.nstb));
      check({v.name, " rdata"}, resp_rdata, v.rdata);
      check({v.name, " err"}, 32'(resp_err), 32'(v.err));
      // Hold off the consumer and confirm the response does not move.
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         check({v.name, " hold valid"}, 32'(resp_valid), 32'd1);
         check({v.name, " hold rdata"}, resp_rdata, v.rdata);
         check({v.name, " hold ready"}, 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check({v.name, " back to idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
   endtask

   task automatic reset_mid_op();
      int writes = 0;
      cur_a0 = 32'h0; cur_w0 = 32'h0; cur_w1 = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
`ifdef MISALIGN_SPLIT_EN
      req_addr = 32'h8000_0007; req_wdata = 32'hAABB_CCDD;
`else
      req_addr = 32'h8000_0040; req_wdata = 32'h1122_3344;
`endif
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_write) writes++;
      check("rst first write", 32'(mem_write), 32'd1);
      @(posedge clk); #1;
`ifdef MISALIGN_SPLIT_EN
      check("rst in acc1", mem_addr, 32'h8000_0008);
`else
      check("rst in settle", 32'(mem_write), 32'd0);
`endif
      rst_n = 1'b0;
      #1;
      check("rst outputs zero", 32'(outs_any()), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (mem_write) writes++;
      end
      check("rst write count", 32'(writes), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst release idle", {30'd0, resp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      cur_a0 = 32'd0; cur_w0 = 32'd0; cur_w1 = 32'd0;

      vecs.push_back(mk("lw", 0, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 0, 1,
                        32'h8000_0010, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 2));
      vecs.push_back(mk("lb", 0, 3'b000, 32'h8000_0013, 0, 32'h80FF_1234, 0, 1,
                        32'h8000_0010, 4'h8, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 2));
      vecs.push_back(mk("lbu", 0, 3'b100, 32'h8000_0013, 0, 32'h80FF_1234, 0, 1,
                        32'h8000_0010, 4'h8, 0, 0, 0, 0, 32'h0000_0080, 0, 2));
      vecs.push_back(mk("sh", 1, 3'b001, 32'h8000_0022, 32'h0000_ABCD, 0, 0, 1,
                        32'h8000_0020, 4'hC, 32'hABCD_0000, 0, 0, 0, 0, 0, 2 + WS));
      vecs.push_back(mk("lh", 0, 3'b001, 32'h8000_0002, 0, 32'h8001_7FFF, 0, 1,
                        32'h8000_0000, 4'hC, 0, 0, 0, 0, 32'hFFFF_8001, 0, 2));
      vecs.push_back(mk("lhu", 0, 3'b101, 32'h8000_0000, 0, 32'h1234_F00D, 0, 1,
                        32'h8000_0000, 4'h3, 0, 0, 0, 0, 32'h0000_F00D, 0, 2));
      vecs.push_back(mk("sb", 1, 3'b000, 32'h8000_0001, 32'h1234_5678, 0, 0, 1,
                        32'h8000_0000, 4'h2, 32'h3456_7800, 0, 0, 0, 0, 0, 2 + WS));
      vecs.push_back(mk("sw", 1, 3'b010, 32'h8000_0040, 32'h1122_3344, 0, 0, 1,
                        32'h8000_0040, 4'hF, 32'h1122_3344, 0, 0, 0, 0, 0, 2 + WS));
      vecs.push_back(mk("ld f3=011", 0, 3'b011, 32'h8000_0010, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk("st f3=100", 1, 3'b100, 32'h8000_0010, 32'h55, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk("ld f3=110", 0, 3'b110, 32'h8000_0010, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
`ifdef MISALIGN_SPLIT_EN
      vecs.push_back(mk("lw split", 0, 3'b010, 32'h8000_0006, 0, 32'h4433_2211,
                        32'h8877_6655, 2, 32'h8000_0004, 4'hC, 0, 32'h8000_0008, 4'h3, 0,
                        32'h6655_4433, 0, 3));
      vecs.push_back(mk("sw split", 1, 3'b010, 32'h8000_0007, 32'hAABB_CCDD, 0, 0, 2,
                        32'h8000_0004, 4'h8, 32'hDD00_0000, 32'h8000_0008, 4'h7,
                        32'h00AA_BBCC, 0, 0, 3 + WS));
      vecs.push_back(mk("lh odd", 0, 3'b001, 32'h8000_0001, 0, 32'h00AB_CD00, 0, 1,
                        32'h8000_0000, 4'h6, 0, 0, 0, 0, 32'hFFFF_ABCD, 0, 2));
      vecs.push_back(mk("lw wrap", 0, 3'b010, 32'hFFFF_FFFE, 0, 32'h2211_0000,
                        32'h0000_4433, 2, 32'hFFFF_FFFC, 4'hC, 0, 32'h0000_0000, 4'h3, 0,
                        32'h4433_2211, 0, 3));
`else
      vecs.push_back(mk("lw misaligned", 0, 3'b010, 32'h8000_0006, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk("sw misaligned", 1, 3'b010, 32'h8000_0007, 32'hAABB_CCDD, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk("lh odd", 0, 3'b001, 32'h8000_0001, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 1, 1));
`endif

      #12;
      check("reset outputs zero", 32'(outs_any()), 32'd0);
      @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset req_ready", 32'(req_ready), 32'd1);
      check("post-reset resp_valid", 32'(resp_valid), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);
      reset_mid_op();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
